fruit_motion: RTL and testbench



---
 rtl/fruit_motion_if.sv | 27 ++
 rtl/fruit_motion.sv | 144 ++++++++++++++
 tb/tb_fruit_motion.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fruit_motion_if.sv
// Request, launch and sprite-status signals exchanged between the game
// controller / renderer (master) and the fruit trajectory engine (slave).
interface fruit_motion_if;
  logic               vs;
  logic               launch;
  logic        [9:0]  launch_x;
  logic signed [5:0]  launch_vx;
  logic        [5:0]  launch_vy;
  logic               slice;
  logic signed [10:0] fruit_x;
  logic signed [10:0] fruit_y;
  logic               fruit_visible;
  logic               sliced;
  logic               busy;
  logic               missed;
  logic               done;

  modport master (
    output vs, launch, launch_x, launch_vx, launch_vy, slice,
    input  fruit_x, fruit_y, fruit_visible, sliced, busy, missed, done
  );

  modport slave (
    input  vs, launch, launch_x, launch_vx, launch_vy, slice,
    output fruit_x, fruit_y, fruit_visible, sliced, busy, missed, done
  );
endinterface

// File: rtl/fruit_motion.sv
// Per-fruit ballistic trajectory engine: launches one fruit, steps its
// position once per video frame under gravity, handles slicing, detects
// screen exit and publishes the sprite top-left position and visibility.
module fruit_motion #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPRITE_DIM = 60,
  parameter int GRAVITY    = 1,
  parameter int TERM_VEL   = 20
) (
  input  logic           vga_clk,
  input  logic           reset_n,
  fruit_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    SLICED
  } state_t;

  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H);
  localparam logic signed [10:0] X_MIN  = 11'(-SPRITE_DIM);
  localparam logic signed [7:0]  GRAV   = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_MIN = 8'(-TERM_VEL);

  state_t             state, state_n;
  logic               vs_d;
  logic               tick;
  logic signed [10:0] x, y, x_n, y_n;
  logic signed [5:0]  vx, vx_n;
  logic signed [7:0]  vy, vy_n;
  logic               missed_q, done_q, visible_q;
  logic               missed_n, done_n, visible_n;

  // One-frame motion candidate, shared by FLY and SLICED.
  logic signed [7:0]  vy_dec, vy_mv;
  logic signed [10:0] x_mv, y_mv;
  logic               exit_mv;

  assign tick = vs_d & ~bus.vs;

  // Gravity step with terminal-velocity clamp, then position step using the new vy.
  always_comb begin
    vy_dec  = vy - GRAV;
    vy_mv   = (vy_dec < VY_MIN) ? VY_MIN : vy_dec;
    x_mv    = x + {{5{vx[5]}}, vx};
    y_mv    = y - {{3{vy_mv[7]}}, vy_mv};
    exit_mv = ((y_mv >= Y_MAX) && vy_mv[7]) || (x_mv <= X_MIN) || (x_mv >= X_MAX);
  end

  // Next-state, next-datapath and registered-output decode.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    vx_n     = vx;
    vy_n     = vy;
    missed_n = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.launch) begin
          x_n     = {1'b0, bus.launch_x};
          y_n     = Y_MAX;
          vx_n    = bus.launch_vx;
          vy_n    = {2'b00, bus.launch_vy};
          state_n = FLY;
        end
      end
      FLY: begin
        // A slice coinciding with a tick takes priority and suppresses that step.
        if (bus.slice) begin
          vy_n    = '0;
          state_n = SLICED;
        end else if (tick) begin
          x_n  = x_mv;
          y_n  = y_mv;
          vy_n = vy_mv;
          if (exit_mv) begin
            state_n  = IDLE;
            missed_n = 1'b1;
            done_n   = 1'b1;
          end
        end
      end
      SLICED: begin
        if (tick) begin
          x_n  = x_mv;
          y_n  = y_mv;
          vy_n = vy_mv;
          if (exit_mv) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    visible_n = (state_n != IDLE) && (y_n < Y_MAX) && (x_n > X_MIN) && (x_n < X_MAX);
  end

  // State register, frame-edge detector and pulse/visibility flags.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      vs_d      <= 1'b1;
      missed_q  <= 1'b0;
      done_q    <= 1'b0;
      visible_q <= 1'b0;
    end else begin
      state     <= state_n;
      vs_d      <= bus.vs;
      missed_q  <= missed_n;
      done_q    <= done_n;
      visible_q <= visible_n;
    end
  end

  // Position and velocity registers; x/y drive fruit_x/fruit_y directly.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      x  <= '0;
      y  <= '0;
      vx <= '0;
      vy <= '0;
    end else begin
      x  <= x_n;
      y  <= y_n;
      vx <= vx_n;
      vy <= vy_n;
    end
  end

  assign bus.fruit_x       = x;
  assign bus.fruit_y       = y;
  assign bus.fruit_visible = visible_q;
  assign bus.sliced        = (state == SLICED);
  assign bus.busy          = (state != IDLE);
  assign bus.missed        = missed_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_fruit_motion.sv
// Bench for fruit_motion: a frame-level reference model pushes expected
// sprite status into a queue per driven frame tick; each scenario pops and
// compares once the DUT edge has been taken.
module tb_fruit_motion;

  logic vga_clk = 1'b0;
  logic reset_n;

  fruit_motion_if mif ();

  fruit_motion #(
    .SCREEN_W  (640),
    .SCREEN_H  (480),
    .SPRITE_DIM(60),
    .GRAVITY   (1),
    .TERM_VEL  (20)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .bus    (mif)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x;
    int y;
    bit busy;
    bit sliced;
    bit vis;
    bit missed;
    bit done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Reference model state (0 idle, 1 fly, 2 sliced).
  int mst, mx, my, mvx, mvy;
  bit m_missed, m_done, m_vis;

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic model_reset();
    mst = 0; mx = 0; my = 0; mvx = 0; mvy = 0;
    m_missed = 0; m_done = 0; m_vis = 0;
  endtask

  task automatic model_tick();
    m_missed = 0;
    m_done   = 0;
    if (mst != 0) begin
      mvy = mvy - 1;
      if (mvy < -20) mvy = -20;
      mx = mx + mvx;
      my = my - mvy;
      if ((my >= 480 && mvy < 0) || mx <= -60 || mx >= 640) begin
        m_missed = (mst == 1);
        m_done   = 1;
        mst      = 0;
      end
    end
    m_vis = (mst != 0) && (my < 480) && (mx > -60) && (mx < 640);
  endtask

  task automatic push_exp();
    sb.push_back('{x: mx, y: my, busy: (mst != 0), sliced: (mst == 2),
                   vis: m_vis, missed: m_missed, done: m_done});
  endtask

  // One frame: a vs-high cycle to arm the edge detector, then the falling edge.
  task automatic drive_tick();
    mif.vs = 1'b1;
    cyc();
    model_tick();
    push_exp();
    mif.vs = 1'b0;
    cyc();
    mif.vs = 1'b1;
  endtask

  task automatic do_launch(input int lx, input int lvx, input int lvy);
    mif.launch_x  = 10'(lx);
    mif.launch_vx = 6'(lvx);
    mif.launch_vy = 6'(lvy);
    mif.launch    = 1'b1;
    cyc();
    mif.launch    = 1'b0;
    if (mst == 0) begin
      mx = lx; my = 480; mvx = lvx; mvy = lvy; mst = 1;
    end
    m_missed = 0; m_done = 0; m_vis = 0;
  endtask

  task automatic do_slice();
    mif.slice = 1'b1;
    cyc();
    mif.slice = 1'b0;
    if (mst == 1) begin
      mvy = 0; mst = 2;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    model_reset();
    total++; if (mif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mif.busy); end
    total++; if (mif.fruit_x !== 11'(0)) begin bad++; $display("FAIL reset_x got=%0d exp=0", mif.fruit_x); end
    total++; if (mif.fruit_y !== 11'(0)) begin bad++; $display("FAIL reset_y got=%0d exp=0", mif.fruit_y); end
    total++; if ({mif.fruit_visible, mif.sliced, mif.missed, mif.done} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {mif.fruit_visible, mif.sliced, mif.missed, mif.done});
    end
  endtask

  task automatic test_vertical_arc();
    int want;
    do_launch(290, 0, 10);
    total++; if (mif.busy !== 1'b1) begin bad++; $display("FAIL arc_launch_busy got=%b exp=1", mif.busy); end
    total++; if (mif.fruit_y !== 11'(480)) begin bad++; $display("FAIL arc_launch_y got=%0d exp=480", mif.fruit_y); end
    total++; if (mif.fruit_visible !== 1'b0) begin bad++; $display("FAIL arc_launch_vis got=%b exp=0", mif.fruit_visible); end
    for (int i = 1; i <= 19; i++) begin
      drive_tick();
      e = sb.pop_front();
      total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL arc_y tick%0d got=%0d exp=%0d", i, mif.fruit_y, e.y); end
      total++; if (mif.fruit_x !== 11'(290)) begin bad++; $display("FAIL arc_x tick%0d got=%0d exp=290", i, mif.fruit_x); end
      total++; if ({mif.missed, mif.done, mif.fruit_visible} !== {e.missed, e.done, e.vis}) begin
        bad++; $display("FAIL arc_flags tick%0d got=%b exp=%b", i, {mif.missed, mif.done, mif.fruit_visible}, {e.missed, e.done, e.vis});
      end
      case (i)
        1: want = 471;
        2: want = 463;
        10: want = 435;
        19: want = 480;
        default: want = -1;
      endcase
      if (want >= 0) begin
        total++; if (mif.fruit_y !== 11'(want)) begin bad++; $display("FAIL arc_point tick%0d got=%0d exp=%0d", i, mif.fruit_y, want); end
      end
      if (i == 19) begin
        total++; if ({mif.missed, mif.done} !== 2'b11) begin bad++; $display("FAIL arc_exit_pulse got=%b exp=11", {mif.missed, mif.done}); end
      end
    end
    cyc();
    total++; if ({mif.missed, mif.done, mif.busy} !== 3'b000) begin
      bad++; $display("FAIL arc_after_exit got=%b exp=000", {mif.missed, mif.done, mif.busy});
    end
    total++; if (mif.fruit_y !== 11'(480) || mif.fruit_x !== 11'(290)) begin
      bad++; $display("FAIL arc_retain got=%0d,%0d exp=290,480", mif.fruit_x, mif.fruit_y);
    end
  endtask

  task automatic test_left_exit();
    do_launch(10, -5, 20);
    for (int i = 1; i <= 14; i++) begin
      drive_tick();
      e = sb.pop_front();
      total++; if (mif.fruit_x !== 11'(e.x)) begin bad++; $display("FAIL left_x tick%0d got=%0d exp=%0d", i, mif.fruit_x, e.x); end
      total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL left_y tick%0d got=%0d exp=%0d", i, mif.fruit_y, e.y); end
      total++; if ({mif.missed, mif.fruit_visible, mif.busy} !== {e.missed, e.vis, e.busy}) begin
        bad++; $display("FAIL left_flags tick%0d got=%b exp=%b", i, {mif.missed, mif.fruit_visible, mif.busy}, {e.missed, e.vis, e.busy});
      end
      if (i == 12) begin
        total++; if (mif.fruit_x !== 11'(-50)) begin bad++; $display("FAIL left_x12 got=%0d exp=-50", mif.fruit_x); end
      end
      if (i == 13) begin
        total++; if (mif.fruit_visible !== 1'b1) begin bad++; $display("FAIL left_vis13 got=%b exp=1", mif.fruit_visible); end
      end
      if (i == 14) begin
        total++; if ({mif.missed, mif.fruit_visible, mif.fruit_x} !== {1'b1, 1'b0, 11'(-60)}) begin
          bad++; $display("FAIL left_exit got=missed%b vis%b x%0d exp=missed1 vis0 x-60", mif.missed, mif.fruit_visible, mif.fruit_x);
        end
      end
    end
    cyc();
  endtask

  task automatic test_slice();
    do_launch(290, 0, 10);
    for (int i = 1; i <= 3; i++) begin
      drive_tick();
      e = sb.pop_front();
      total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL slice_pre_y tick%0d got=%0d exp=%0d", i, mif.fruit_y, e.y); end
    end
    total++; if (mif.fruit_y !== 11'(456)) begin bad++; $display("FAIL slice_y3 got=%0d exp=456", mif.fruit_y); end
    cyc();
    do_slice();
    total++; if ({mif.sliced, mif.busy} !== 2'b11) begin bad++; $display("FAIL slice_state got=%b exp=11", {mif.sliced, mif.busy}); end
    total++; if (mif.fruit_y !== 11'(456)) begin bad++; $display("FAIL slice_hold_y got=%0d exp=456", mif.fruit_y); end
    for (int i = 4; i <= 10; i++) begin
      drive_tick();
      e = sb.pop_front();
      total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL slice_y tick%0d got=%0d exp=%0d", i, mif.fruit_y, e.y); end
      total++; if ({mif.done, mif.missed, mif.sliced} !== {e.done, e.missed, e.sliced}) begin
        bad++; $display("FAIL slice_flags tick%0d got=%b exp=%b", i, {mif.done, mif.missed, mif.sliced}, {e.done, e.missed, e.sliced});
      end
      if (i == 4) begin
        total++; if (mif.fruit_y !== 11'(457)) begin bad++; $display("FAIL slice_y4 got=%0d exp=457", mif.fruit_y); end
      end
      if (i == 10) begin
        total++; if ({mif.fruit_y, mif.done, mif.missed} !== {11'(484), 1'b1, 1'b0}) begin
          bad++; $display("FAIL slice_exit got=y%0d done%b missed%b exp=y484 done1 missed0", mif.fruit_y, mif.done, mif.missed);
        end
      end
    end
    cyc();
    total++; if ({mif.done, mif.busy} !== 2'b00) begin bad++; $display("FAIL slice_after got=%b exp=00", {mif.done, mif.busy}); end
  endtask

  task automatic test_coincidence();
    int n;
    cyc();
    // Launch on the tick edge: no motion until the following frame.
    mif.launch_x  = 10'(100);
    mif.launch_vx = 6'(0);
    mif.launch_vy = 6'(10);
    mif.launch    = 1'b1;
    mif.vs        = 1'b0;
    cyc();
    mif.launch    = 1'b0;
    mif.vs        = 1'b1;
    mx = 100; my = 480; mvx = 0; mvy = 10; mst = 1;
    total++; if ({mif.busy, mif.fruit_y} !== {1'b1, 11'(480)}) begin
      bad++; $display("FAIL coin_launch got=busy%b y%0d exp=busy1 y480", mif.busy, mif.fruit_y);
    end
    drive_tick();
    e = sb.pop_front();
    total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL coin_first_y got=%0d exp=%0d", mif.fruit_y, e.y); end
    // Slice on the tick edge: slice wins, no motion.
    cyc();
    mif.slice = 1'b1;
    mif.vs    = 1'b0;
    cyc();
    mif.slice = 1'b0;
    mif.vs    = 1'b1;
    mvy = 0; mst = 2;
    total++; if ({mif.sliced, mif.fruit_y} !== {1'b1, 11'(471)}) begin
      bad++; $display("FAIL coin_slice got=sliced%b y%0d exp=sliced1 y471", mif.sliced, mif.fruit_y);
    end
    n = 0;
    while (mst != 0 && n < 60) begin
      drive_tick();
      e = sb.pop_front();
      n++;
      total++; if ({mif.fruit_y, mif.done, mif.missed} !== {11'(e.y), e.done, e.missed}) begin
        bad++; $display("FAIL coin_fall step%0d got=y%0d d%b m%b exp=y%0d d%b m%b", n, mif.fruit_y, mif.done, mif.missed, e.y, e.done, e.missed);
      end
    end
    cyc();
    total++; if (mif.busy !== 1'b0) begin bad++; $display("FAIL coin_end_busy got=%b exp=0", mif.busy); end
  endtask

  task automatic test_ignored();
    mif.slice = 1'b1;
    cyc();
    mif.slice = 1'b0;
    total++; if ({mif.busy, mif.sliced} !== 2'b00) begin bad++; $display("FAIL ign_idle_slice got=%b exp=00", {mif.busy, mif.sliced}); end
    do_launch(300, 2, 15);
    drive_tick();
    e = sb.pop_front();
    total++; if ({mif.fruit_x, mif.fruit_y} !== {11'(e.x), 11'(e.y)}) begin
      bad++; $display("FAIL ign_t1 got=%0d,%0d exp=%0d,%0d", mif.fruit_x, mif.fruit_y, e.x, e.y);
    end
    do_launch(100, -3, 5);
    total++; if ({mif.fruit_x, mif.fruit_y} !== {11'(302), 11'(466)}) begin
      bad++; $display("FAIL ign_launch_pos got=%0d,%0d exp=302,466", mif.fruit_x, mif.fruit_y);
    end
    drive_tick();
    e = sb.pop_front();
    total++; if ({mif.fruit_x, mif.fruit_y} !== {11'(e.x), 11'(e.y)}) begin
      bad++; $display("FAIL ign_launch_vel got=%0d,%0d exp=%0d,%0d", mif.fruit_x, mif.fruit_y, e.x, e.y);
    end
    // vs held low for 100 cycles is a single frame edge.
    cyc();
    model_tick();
    push_exp();
    mif.vs = 1'b0;
    repeat (100) cyc();
    mif.vs = 1'b1;
    e = sb.pop_front();
    total++; if ({mif.fruit_x, mif.fruit_y} !== {11'(e.x), 11'(e.y)}) begin
      bad++; $display("FAIL ign_vs_low got=%0d,%0d exp=%0d,%0d", mif.fruit_x, mif.fruit_y, e.x, e.y);
    end
    cyc();
    total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL ign_vs_rise got=%0d exp=%0d", mif.fruit_y, e.y); end
  endtask

  task automatic test_reset_midflight();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    model_reset();
    do_launch(200, 1, 12);
    for (int i = 1; i <= 3; i++) begin
      drive_tick();
      e = sb.pop_front();
      total++; if (mif.fruit_y !== 11'(e.y)) begin bad++; $display("FAIL rst_pre_y tick%0d got=%0d exp=%0d", i, mif.fruit_y, e.y); end
    end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    model_reset();
    total++; if ({mif.busy, mif.missed, mif.done, mif.fruit_visible} !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_flags got=%b exp=0000", {mif.busy, mif.missed, mif.done, mif.fruit_visible});
    end
    total++; if ({mif.fruit_x, mif.fruit_y} !== 22'b0) begin
      bad++; $display("FAIL rst_mid_pos got=%0d,%0d exp=0,0", mif.fruit_x, mif.fruit_y);
    end
    cyc();
    total++; if ({mif.busy, mif.missed, mif.done} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_after got=%b exp=000", {mif.busy, mif.missed, mif.done});
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    mif.vs        = 1'b1;
    mif.launch    = 1'b0;
    mif.launch_x  = '0;
    mif.launch_vx = '0;
    mif.launch_vy = '0;
    mif.slice     = 1'b0;
    model_reset();
    test_reset();
    test_vertical_arc();
    test_left_exit();
    test_slice();
    test_coincidence();
    test_ignored();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
